// File: rtl/multicycle_ctrl_if.sv
// Handshake/select bundle between the multicycle RV32I control FSM and its datapath/memory.
// The trap member exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             mem_ready;
    logic             alu_zero;
    logic             alu_lsb;
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             alu_ctrl;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic             rf_we;
    logic [1:0]       result_src;
    logic [CNT_W-1:0] retired_cnt;
`ifdef ILLEGAL_TRAP_EN
    logic             trap;
`endif

    modport master (
        input  instr, mem_ready, alu_zero, alu_lsb,
        output mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, alu_ctrl,
        output alu_src_a, alu_src_b, rf_we, result_src, retired_cnt
`ifdef ILLEGAL_TRAP_EN
        , output trap
`endif
    );

    modport slave (
        output instr, mem_ready, alu_zero, alu_lsb,
        input  mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, alu_ctrl,
        input  alu_src_a, alu_src_b, rf_we, result_src, retired_cnt
`ifdef ILLEGAL_TRAP_EN
        , input trap
`endif
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (shared ALU, shared memory port).
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state instead of treating them as NOPs.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    multicycle_ctrl_if.master     bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC, S_ALU_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_EXEC_JALR, S_JUMP, S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired_cnt;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_taken;
    logic       w_unused_bits;

    assign w_opcode      = bus.instr[6:0];
    assign w_funct3      = bus.instr[14:12];
    assign w_unused_bits = ^{bus.instr[31:15], bus.instr[11:7]};

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:         w_taken = bus.alu_zero;
            3'b001:         w_taken = !bus.alu_zero;
            3'b100, 3'b110: w_taken = bus.alu_lsb;
            3'b101, 3'b111: w_taken = !bus.alu_lsb;
            default:        w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:      if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    7'b0110011:             w_next = S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: w_next = S_MEM_ADDR;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JUMP;
                    7'b1100111:             w_next = S_EXEC_JALR;
                    7'b0110111:             w_next = S_EXEC_LUI;
                    7'b0010111:             w_next = S_EXEC_AUIPC;
                    7'b0001111, 7'b1110011: w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                    default:                w_next = S_TRAP;
`else
                    default:                w_next = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC: w_next = S_ALU_WB;
            S_ALU_WB:     w_next = S_FETCH;
            S_MEM_ADDR:   w_next = (w_opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:     if (bus.mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:     w_next = S_FETCH;
            S_MEM_WR:     if (bus.mem_ready) w_next = S_FETCH;
            S_BRANCH:     w_next = S_FETCH;
            S_EXEC_JALR:  w_next = S_JUMP;
            S_JUMP:       w_next = S_FETCH;
            default:      w_next = r_state;
        endcase
    end

    // A retirement is any arrival in FETCH from elsewhere; TRAP never arrives there.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_FETCH;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    logic       w_mem_req, w_mem_we, w_adr_src, w_ir_we, w_pc_we, w_pc_src, w_alu_ctrl, w_rf_we;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src;
`ifdef ILLEGAL_TRAP_EN
    logic       w_trap;
`endif

    // Outputs are forced low while rstn is low so an in-flight request is dropped at once.
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_ctrl   = 1'b0;
        w_rf_we      = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
`ifdef ILLEGAL_TRAP_EN
        w_trap       = 1'b0;
`endif
        if (rstn) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req   = 1'b1;
                    w_alu_ctrl  = 1'b1;
                    w_alu_src_b = 2'b10;
                    w_ir_we     = bus.mem_ready;
                    w_pc_we     = bus.mem_ready;
                end
                S_DECODE, S_EXEC_AUIPC: begin
                    w_alu_ctrl  = 1'b1;
                    w_alu_src_a = 2'b01;
                    w_alu_src_b = 2'b01;
                end
                S_EXEC_R: w_alu_src_a = 2'b10;
                S_EXEC_I: begin
                    w_alu_src_a = 2'b10;
                    w_alu_src_b = 2'b01;
                end
                S_EXEC_LUI: begin
                    w_alu_ctrl  = 1'b1;
                    w_alu_src_a = 2'b11;
                    w_alu_src_b = 2'b01;
                end
                S_ALU_WB: w_rf_we = 1'b1;
                S_MEM_ADDR, S_EXEC_JALR: begin
                    w_alu_ctrl  = 1'b1;
                    w_alu_src_a = 2'b10;
                    w_alu_src_b = 2'b01;
                end
                S_MEM_RD: begin
                    w_mem_req = 1'b1;
                    w_adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    w_rf_we      = 1'b1;
                    w_result_src = 2'b01;
                end
                S_MEM_WR: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                    w_adr_src = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_src_a = 2'b10;
                    w_pc_we     = w_taken;
                    w_pc_src    = w_taken;
                end
                S_JUMP: begin
                    w_rf_we      = 1'b1;
                    w_result_src = 2'b10;
                    w_pc_we      = 1'b1;
                    w_pc_src     = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: w_trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.adr_src     = w_adr_src;
    assign bus.ir_we       = w_ir_we;
    assign bus.pc_we       = w_pc_we;
    assign bus.pc_src      = w_pc_src;
    assign bus.alu_ctrl    = w_alu_ctrl;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.rf_we       = w_rf_we;
    assign bus.result_src  = w_result_src;
    assign bus.retired_cnt = r_retired_cnt;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap        = w_trap;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors and retired counts for each instruction class.
// Handles both builds of ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus();
    multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    // {mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, alu_ctrl, a[1:0], b[1:0], rf_we, result_src[1:0]}
    localparam logic [13:0] O_ZERO  = 14'b0_0_0_0_0_0_0_00_00_0_00;
    localparam logic [13:0] O_FWAIT = 14'b1_0_0_0_0_0_1_00_10_0_00;
    localparam logic [13:0] O_FRDY  = 14'b1_0_0_1_1_0_1_00_10_0_00;
    localparam logic [13:0] O_DEC   = 14'b0_0_0_0_0_0_1_01_01_0_00;
    localparam logic [13:0] O_EXR   = 14'b0_0_0_0_0_0_0_10_00_0_00;
    localparam logic [13:0] O_EXI   = 14'b0_0_0_0_0_0_0_10_01_0_00;
    localparam logic [13:0] O_LUI   = 14'b0_0_0_0_0_0_1_11_01_0_00;
    localparam logic [13:0] O_AUIPC = 14'b0_0_0_0_0_0_1_01_01_0_00;
    localparam logic [13:0] O_AWB   = 14'b0_0_0_0_0_0_0_00_00_1_00;
    localparam logic [13:0] O_MADR  = 14'b0_0_0_0_0_0_1_10_01_0_00;
    localparam logic [13:0] O_MRD   = 14'b1_0_1_0_0_0_0_00_00_0_00;
    localparam logic [13:0] O_MWB   = 14'b0_0_0_0_0_0_0_00_00_1_01;
    localparam logic [13:0] O_MWR   = 14'b1_1_1_0_0_0_0_00_00_0_00;
    localparam logic [13:0] O_BRT   = 14'b0_0_0_0_1_1_0_10_00_0_00;
    localparam logic [13:0] O_BRN   = 14'b0_0_0_0_0_0_0_10_00_0_00;
    localparam logic [13:0] O_JMP   = 14'b0_0_0_0_1_1_0_00_00_1_10;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_we, bus.pc_we, bus.pc_src,
                bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.rf_we, bus.result_src};
    endfunction

    // Entered at posedge+1: drive mem_ready, check mid-cycle, advance to next posedge+1.
    task automatic cyc(input string tag, input logic rdy, input logic [13:0] exp);
        bus.mem_ready = rdy;
        #4;
        check(tag, {18'd0, outs()}, {18'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input string name);
        exp_cnt = exp_cnt + 1;
        check({name, "_cnt"}, bus.retired_cnt, exp_cnt);
        $display("instr %s retired, retired_cnt=%0d", name, bus.retired_cnt);
    endtask

    task automatic fetch_decode(input logic [31:0] ins);
        bus.instr = ins;
        cyc("fetch", 1'b1, O_FRDY);
        cyc("decode", 1'b1, O_DEC);
    endtask

    task automatic branch(input string name, input logic [31:0] ins, input logic z, input logic l,
                          input logic [13:0] exp);
        fetch_decode(ins);
        bus.alu_zero = z;
        bus.alu_lsb  = l;
        cyc(name, 1'b1, exp);
        bus.alu_zero = 1'b0;
        bus.alu_lsb  = 1'b0;
        retire(name);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.instr     = 32'h0;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b0;
        bus.alu_lsb   = 1'b0;
        @(posedge clk);
        #1;

        // reset held two cycles with mem_ready high
        cyc("rst0", 1'b1, O_ZERO);
        cyc("rst1", 1'b1, O_ZERO);
        check("rst_cnt", bus.retired_cnt, 32'd0);
        rstn = 1'b1;
        cyc("fetch_stall", 1'b0, O_FWAIT);
        cyc("fetch_stall2", 1'b0, O_FWAIT);
        check("stall_cnt", bus.retired_cnt, 32'd0);

        // ADD x3,x1,x2
        fetch_decode(32'h002081B3);
        cyc("exec_r", 1'b1, O_EXR);
        cyc("alu_wb", 1'b1, O_AWB);
        retire("add");

        // LW with three wait cycles in MEM_RD
        fetch_decode(32'h0000A183);
        cyc("mem_addr_ld", 1'b1, O_MADR);
        cyc("mem_rd_w0", 1'b0, O_MRD);
        cyc("mem_rd_w1", 1'b0, O_MRD);
        cyc("mem_rd_w2", 1'b0, O_MRD);
        cyc("mem_rd_rdy", 1'b1, O_MRD);
        cyc("mem_wb", 1'b1, O_MWB);
        retire("lw");

        // branches: funct3 decode and flag polarity
        branch("beq_t",  32'h00208063, 1'b1, 1'b0, O_BRT);
        branch("beq_n",  32'h00208063, 1'b0, 1'b0, O_BRN);
        branch("bne_t",  32'h00209063, 1'b0, 1'b0, O_BRT);
        branch("bltu_n", 32'h0020E063, 1'b1, 1'b0, O_BRN);
        branch("bltu_t", 32'h0020E063, 1'b0, 1'b1, O_BRT);
        branch("bge_t",  32'h0020D063, 1'b0, 1'b0, O_BRT);
        branch("f3_010", 32'h0020A063, 1'b1, 1'b1, O_BRN);

        // JAL and JALR
        fetch_decode(32'h0000006F);
        cyc("jal_jump", 1'b1, O_JMP);
        retire("jal");
        fetch_decode(32'h00008067);
        cyc("jalr_exec", 1'b1, O_MADR);
        cyc("jalr_jump", 1'b1, O_JMP);
        retire("jalr");

        // ADDI, LUI, AUIPC
        fetch_decode(32'h00108093);
        cyc("exec_i", 1'b1, O_EXI);
        cyc("alu_wb_i", 1'b1, O_AWB);
        retire("addi");
        fetch_decode(32'h000000B7);
        cyc("exec_lui", 1'b1, O_LUI);
        cyc("alu_wb_lui", 1'b1, O_AWB);
        retire("lui");
        fetch_decode(32'h00000097);
        cyc("exec_auipc", 1'b1, O_AUIPC);
        cyc("alu_wb_auipc", 1'b1, O_AWB);
        retire("auipc");

        // SW with one wait cycle
        fetch_decode(32'h0020A023);
        cyc("mem_addr_st", 1'b1, O_MADR);
        cyc("mem_wr_w0", 1'b0, O_MWR);
        cyc("mem_wr_rdy", 1'b1, O_MWR);
        retire("sw");

        // FENCE: two cycles
        fetch_decode(32'h0000000F);
        retire("fence");

        // unknown opcode 0x7F
        fetch_decode(32'h0000007F);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #4;
            check("trap_flag", {31'd0, bus.trap}, 32'd1);
            check("trap_outs", {18'd0, outs()}, {18'd0, O_ZERO});
            @(posedge clk);
            #1;
        end
        check("trap_cnt", bus.retired_cnt, exp_cnt);
        $display("instr illegal trapped, retired_cnt=%0d", bus.retired_cnt);
        rstn = 1'b0;
        cyc("trap_rst", 1'b1, O_ZERO);
        rstn = 1'b1;
        exp_cnt = 32'd0;
        check("trap_clr", {31'd0, bus.trap}, 32'd0);
        check("trap_rst_cnt", bus.retired_cnt, exp_cnt);
`else
        retire("illegal_nop");
`endif

        // reset during a stalled store drops mem_req immediately
        fetch_decode(32'h0020A023);
        cyc("mem_addr_st2", 1'b1, O_MADR);
        cyc("mem_wr_stall", 1'b0, O_MWR);
        rstn = 1'b0;
        cyc("mem_wr_rst", 1'b0, O_ZERO);
        rstn = 1'b1;
        cyc("post_rst_fetch", 1'b0, O_FWAIT);
        check("post_rst_cnt", bus.retired_cnt, 32'd0);
        $display("instr sw aborted by reset, retired_cnt=%0d", bus.retired_cnt);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
